// File: rtl/deadlock_mon_pkg.sv
// -----------------------------------------------------------------------------
// deadlock_mon_pkg
// Shared definitions for the kernel deadlock monitor:
//   - mon_state_e   : monitor FSM state encoding
//   - DEF_*         : default values for the monitor parameters
//   - cnt_width()   : width of the shared startup/persistence counter
// -----------------------------------------------------------------------------
package deadlock_mon_pkg;

    typedef enum logic [1:0] {
        ST_STARTUP  = 2'd0,
        ST_MONITOR  = 2'd1,
        ST_PENDING  = 2'd2,
        ST_DEADLOCK = 2'd3
    } mon_state_e;

    localparam int         DEF_NUM_AXIS       = 2;
    localparam int         DEF_NUM_INST       = 1;
    localparam int         DEF_STARTUP_CYCLES = 10;
    localparam int         DEF_BLOCK_CYCLES   = 2;
    localparam logic [1:0] DEF_AXIS_IS_WRITE  = 2'b10;

    // One counter serves both the startup window and the blocked-sample run,
    // so it must be able to hold the larger of the two limits.
    function automatic int cnt_width(input int startup_cycles, input int block_cycles);
        int max_v;
        max_v = (startup_cycles > block_cycles) ? startup_cycles : block_cycles;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/deadlock_persist_cnt.sv
// -----------------------------------------------------------------------------
// deadlock_persist_cnt
// Saturating up-counter with clear priority and a look-ahead limit comparator.
// Ports:
//   kernel_monitor_clock  : clock, rising edge
//   kernel_monitor_reset  : synchronous active-low reset
//   clr                   : clear count to zero (dominates inc)
//   inc                   : increment by one, holds at all-ones
//   limit [CNT_W-1:0]     : compare value for limit_hit
//   limit_hit             : 1 when one more increment reaches or passes limit
// -----------------------------------------------------------------------------
module deadlock_persist_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             kernel_monitor_clock,
    input  logic             kernel_monitor_reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             limit_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W:0]   CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;
    logic [CNT_W:0]   count_next_s;

    // Extra bit keeps the look-ahead compare exact even at saturation.
    assign count_next_s = {1'b0, count_r} + CNT_ONE;
    assign limit_hit    = (count_next_s >= {1'b0, limit});

    // Count register: reset, clear, saturating increment.
    always_ff @(posedge kernel_monitor_clock) begin
        if (!kernel_monitor_reset) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_next_s[CNT_W-1:0];
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/deadlock_kernel_monitor_n.sv
// -----------------------------------------------------------------------------
// deadlock_kernel_monitor_n
// Watches a kernel's AXI-Stream stall flags and sub-instance status, and
// declares a sticky deadlock once the kernel has been blocked (and not fully
// idle) for BLOCK_CYCLES consecutive samples after a STARTUP_CYCLES grace
// window. On entry the stall pattern is snapshotted for diagnosis.
// Ports:
//   kernel_monitor_clock            : clock, rising edge
//   kernel_monitor_reset            : synchronous active-low reset
//   axis_block_sigs [NUM_AXIS]      : per-port stalled-by-outer-side flags
//   inst_idle_sigs  [NUM_INST]      : per-instance idle flags
//   inst_block_sigs [NUM_INST]      : per-instance internally-blocked flags
//   diag_clear                      : leave DEADLOCK and re-arm
//   kernel_block                    : raw block indication, one cycle late
//   deadlock                        : sticky deadlock flag
//   deadlock_event                  : one-cycle pulse on DEADLOCK entry
//   axis_snapshot   [NUM_AXIS]      : axis_block_sigs captured at entry
//   first_blocked_idx               : lowest set snapshot bit, MSB=1 if none
//   starved_inputs  [NUM_AXIS]      : snapshot bits of read ports
//   unready_outputs [NUM_AXIS]      : snapshot bits of write ports
// -----------------------------------------------------------------------------
module deadlock_kernel_monitor_n
    import deadlock_mon_pkg::*;
#(
    parameter int                  NUM_AXIS       = DEF_NUM_AXIS,
    parameter int                  NUM_INST       = DEF_NUM_INST,
    parameter int                  STARTUP_CYCLES = DEF_STARTUP_CYCLES,
    parameter int                  BLOCK_CYCLES   = DEF_BLOCK_CYCLES,
    parameter logic [NUM_AXIS-1:0] AXIS_IS_WRITE  = DEF_AXIS_IS_WRITE
) (
    input  logic                      kernel_monitor_clock,
    input  logic                      kernel_monitor_reset,
    input  logic [NUM_AXIS-1:0]       axis_block_sigs,
    input  logic [NUM_INST-1:0]       inst_idle_sigs,
    input  logic [NUM_INST-1:0]       inst_block_sigs,
    input  logic                      diag_clear,
    output logic                      kernel_block,
    output logic                      deadlock,
    output logic                      deadlock_event,
    output logic [NUM_AXIS-1:0]       axis_snapshot,
    output logic [$clog2(NUM_AXIS):0] first_blocked_idx,
    output logic [NUM_AXIS-1:0]       starved_inputs,
    output logic [NUM_AXIS-1:0]       unready_outputs
);

    localparam int                  CNT_W       = cnt_width(STARTUP_CYCLES, BLOCK_CYCLES);
    localparam int                  IDX_W       = $clog2(NUM_AXIS) + 1;
    localparam logic [CNT_W-1:0]    STARTUP_LIM = CNT_W'(STARTUP_CYCLES);
    localparam logic [CNT_W-1:0]    BLOCK_LIM   = CNT_W'(BLOCK_CYCLES);
    localparam logic [IDX_W-1:0]    IDX_NONE    = IDX_W'(32'd1) << (IDX_W - 1);
    localparam logic [NUM_AXIS-1:0] AXIS_ZERO   = {NUM_AXIS{1'b0}};

    mon_state_e          state_r;
    logic                kernel_block_r;
    logic                deadlock_r;
    logic                deadlock_event_r;
    logic [NUM_AXIS-1:0] axis_snapshot_r;

    logic                raw_block_s;
    logic                cnt_clr_s;
    logic                cnt_inc_s;
    logic                cnt_hit_s;
    logic [CNT_W-1:0]    cnt_limit_s;
    logic                enter_deadlock_s;
    logic [IDX_W-1:0]    first_idx_s;

    // A fully idle kernel is never considered blocked, whatever the stall flags say.
    assign raw_block_s = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);

    // The counter measures the startup window first, then blocked-sample runs.
    assign cnt_limit_s = (state_r == ST_STARTUP) ? STARTUP_LIM : BLOCK_LIM;

    // cnt_hit_s is a look-ahead: this sample would complete the required count.
    assign enter_deadlock_s = ((state_r == ST_MONITOR) || (state_r == ST_PENDING))
                              && raw_block_s && cnt_hit_s;

    // Counter control: count while accumulating, clear whenever the run ends.
    always_comb begin
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        case (state_r)
            ST_STARTUP: begin
                if (cnt_hit_s) begin
                    cnt_clr_s = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            ST_MONITOR, ST_PENDING: begin
                if (raw_block_s && !cnt_hit_s) begin
                    cnt_inc_s = 1'b1;
                end else begin
                    cnt_clr_s = 1'b1;
                end
            end
            ST_DEADLOCK: begin
                cnt_clr_s = 1'b1;
            end
            default: begin
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    deadlock_persist_cnt #(
        .CNT_W (CNT_W)
    ) u_persist_cnt (
        .kernel_monitor_clock (kernel_monitor_clock),
        .kernel_monitor_reset (kernel_monitor_reset),
        .clr                  (cnt_clr_s),
        .inc                  (cnt_inc_s),
        .limit                (cnt_limit_s),
        .limit_hit            (cnt_hit_s)
    );

    // Monitor FSM with its registered flags and the entry snapshot.
    always_ff @(posedge kernel_monitor_clock) begin
        if (!kernel_monitor_reset) begin
            state_r          <= ST_STARTUP;
            kernel_block_r   <= 1'b0;
            deadlock_r       <= 1'b0;
            deadlock_event_r <= 1'b0;
            axis_snapshot_r  <= AXIS_ZERO;
        end else begin
            kernel_block_r   <= raw_block_s;
            deadlock_event_r <= 1'b0;
            case (state_r)
                ST_STARTUP: begin
                    if (cnt_hit_s) begin
                        state_r <= ST_MONITOR;
                    end else begin
                        state_r <= ST_STARTUP;
                    end
                end
                ST_MONITOR, ST_PENDING: begin
                    if (enter_deadlock_s) begin
                        state_r          <= ST_DEADLOCK;
                        deadlock_r       <= 1'b1;
                        deadlock_event_r <= 1'b1;
                        axis_snapshot_r  <= axis_block_sigs;
                    end else if (raw_block_s) begin
                        state_r <= ST_PENDING;
                    end else begin
                        state_r <= ST_MONITOR;
                    end
                end
                ST_DEADLOCK: begin
                    // Snapshot is deliberately kept after clearing for post-mortem reads.
                    if (diag_clear) begin
                        state_r    <= ST_MONITOR;
                        deadlock_r <= 1'b0;
                    end else begin
                        state_r <= ST_DEADLOCK;
                    end
                end
                default: begin
                    state_r    <= ST_STARTUP;
                    deadlock_r <= 1'b0;
                end
            endcase
        end
    end

    // Lowest set snapshot bit; scanning downward lets the lowest index win.
    always_comb begin
        first_idx_s = IDX_NONE;
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (axis_snapshot_r[i]) begin
                first_idx_s = IDX_W'(i);
            end else begin
                first_idx_s = first_idx_s;
            end
        end
    end

    assign kernel_block      = kernel_block_r;
    assign deadlock          = deadlock_r;
    assign deadlock_event    = deadlock_event_r;
    assign axis_snapshot     = axis_snapshot_r;
    assign first_blocked_idx = first_idx_s;
    assign starved_inputs    = axis_snapshot_r & ~AXIS_IS_WRITE;
    assign unready_outputs   = axis_snapshot_r & AXIS_IS_WRITE;

endmodule

// File: tb/tb_deadlock_kernel_monitor_n.sv
// -----------------------------------------------------------------------------
// tb_deadlock_kernel_monitor_n
// Self-checking bench. Instance a uses the default configuration and is driven
// from a per-cycle vector table through an expected-result queue; instance b
// (5 ports, no startup window, single-sample deadlock) gets a short
// hand-written sequence.
// -----------------------------------------------------------------------------
module tb_deadlock_kernel_monitor_n;

    logic clk;

    // Instance a: defaults (2 ports, 1 instance, startup 10, block 2, write mask 10)
    logic       a_rst_n;
    logic [1:0] a_axis;
    logic [0:0] a_idle;
    logic [0:0] a_blk;
    logic       a_clr;
    logic       a_kb;
    logic       a_dl;
    logic       a_ev;
    logic [1:0] a_snap;
    logic [1:0] a_idx;
    logic [1:0] a_starved;
    logic [1:0] a_unready;

    // Instance b: 5 ports, startup 0, block 1, write mask 00100
    logic       b_rst_n;
    logic [4:0] b_axis;
    logic [0:0] b_idle;
    logic [0:0] b_blk;
    logic       b_clr;
    logic       b_kb;
    logic       b_dl;
    logic       b_ev;
    logic [4:0] b_snap;
    logic [3:0] b_idx;
    logic [4:0] b_starved;
    logic [4:0] b_unready;

    int n_checks;
    int n_fail;

    deadlock_kernel_monitor_n dut_a (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (a_rst_n),
        .axis_block_sigs      (a_axis),
        .inst_idle_sigs       (a_idle),
        .inst_block_sigs      (a_blk),
        .diag_clear           (a_clr),
        .kernel_block         (a_kb),
        .deadlock             (a_dl),
        .deadlock_event       (a_ev),
        .axis_snapshot        (a_snap),
        .first_blocked_idx    (a_idx),
        .starved_inputs       (a_starved),
        .unready_outputs      (a_unready)
    );

    deadlock_kernel_monitor_n #(
        .NUM_AXIS       (5),
        .NUM_INST       (1),
        .STARTUP_CYCLES (0),
        .BLOCK_CYCLES   (1),
        .AXIS_IS_WRITE  (5'b00100)
    ) dut_b (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (b_rst_n),
        .axis_block_sigs      (b_axis),
        .inst_idle_sigs       (b_idle),
        .inst_block_sigs      (b_blk),
        .diag_clear           (b_clr),
        .kernel_block         (b_kb),
        .deadlock             (b_dl),
        .deadlock_event       (b_ev),
        .axis_snapshot        (b_snap),
        .first_blocked_idx    (b_idx),
        .starved_inputs       (b_starved),
        .unready_outputs      (b_unready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic [1:0] axis;
        logic       idle;
        logic       blk;
        logic       clr;
        logic       exp_kb;
        logic       exp_dl;
        logic       exp_ev;
        logic [1:0] exp_snap;
    } vec_t;

    typedef struct {
        logic       kb;
        logic       dl;
        logic       ev;
        logic [1:0] snap;
        logic [1:0] idx;
        logic [1:0] starved;
        logic [1:0] unready;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    task automatic add(input logic rst_n, input logic [1:0] axis, input logic idle,
                       input logic blk, input logic clr, input logic kb,
                       input logic dl, input logic ev, input logic [1:0] snap);
        vec_t v;
        v.rst_n = rst_n; v.axis = axis; v.idle = idle; v.blk = blk; v.clr = clr;
        v.exp_kb = kb; v.exp_dl = dl; v.exp_ev = ev; v.exp_snap = snap;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Derived outputs for the snapshot patterns the table produces (write mask 2'b10).
    function automatic exp_t with_derived(input logic kb, input logic dl, input logic ev,
                                          input logic [1:0] snap);
        exp_t e;
        e.kb = kb; e.dl = dl; e.ev = ev; e.snap = snap;
        case (snap)
            2'b00:   begin e.idx = 2'b10; e.starved = 2'b00; e.unready = 2'b00; end
            2'b01:   begin e.idx = 2'b00; e.starved = 2'b01; e.unready = 2'b00; end
            2'b10:   begin e.idx = 2'b01; e.starved = 2'b00; e.unready = 2'b10; end
            2'b11:   begin e.idx = 2'b00; e.starved = 2'b01; e.unready = 2'b10; end
            default: begin e.idx = 2'b00; e.starved = 2'b00; e.unready = 2'b00; end
        endcase
        return e;
    endfunction

    initial begin
        vec_t v;
        exp_t e;
        n_checks = 0;
        n_fail   = 0;

        // ---------------- vector table for instance a ----------------
        //   rst axis   idle blk  clr  | kb   dl   ev   snap
        add(1'b0, 2'b11, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 2'b00); // reset beats diag_clear
        for (int i = 1; i <= 10; i++) begin                          // startup window ignores blocking
            add(1'b1, 2'b11, 1'b0, 1'b0, (i == 5) ? 1'b1 : 1'b0,
                1'b1, 1'b0, 1'b0, 2'b00);
        end
        add(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 2'b00); // cycle 11: first counted sample
        add(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 2'b11); // cycle 12: deadlock + event
        add(1'b1, 2'b00, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 2'b11); // sticky, event gone
        add(1'b1, 2'b11, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 2'b11); // clear while blocked
        add(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 2'b11);
        add(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 2'b11); // re-entry after 2 samples
        add(1'b1, 2'b00, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 2'b11); // clear, snapshot kept
        add(1'b1, 2'b01, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 2'b11); // 1 blocked
        add(1'b1, 2'b00, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 2'b11); // gap: no partial credit
        add(1'b1, 2'b01, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 2'b11);
        add(1'b1, 2'b00, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 2'b11);
        add(1'b1, 2'b11, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 2'b11); // idle masks blocking
        add(1'b1, 2'b11, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 2'b11);
        add(1'b1, 2'b11, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 2'b11);
        add(1'b1, 2'b10, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 2'b11); // clear ignored in MONITOR
        add(1'b1, 2'b10, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 2'b10); // clear ignored in PENDING
        add(1'b1, 2'b00, 1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 2'b10); // inst block alone is raw
        add(1'b1, 2'b00, 1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 2'b10);
        add(1'b1, 2'b01, 1'b0, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 2'b01); // snapshot from completing sample
        add(1'b1, 2'b00, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 2'b01); // into PENDING
        add(1'b0, 2'b11, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 2'b00); // reset mid-count
        for (int i = 0; i < 10; i++) begin                           // full startup again
            add(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        end
        add(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 2'b11);
        add(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 0, 2'b11);    // held regardless of raw

        b_rst_n = 1'b0; b_axis = 5'b00000; b_idle = 1'b0; b_blk = 1'b0; b_clr = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            a_rst_n = v.rst_n;
            a_axis  = v.axis;
            a_idle  = v.idle;
            a_blk   = v.blk;
            a_clr   = v.clr;
            exp_q.push_back(with_derived(v.exp_kb, v.exp_dl, v.exp_ev, v.exp_snap));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("a row%0d kernel_block", i), 32'(a_kb), 32'(e.kb));
            check($sformatf("a row%0d deadlock", i), 32'(a_dl), 32'(e.dl));
            check($sformatf("a row%0d deadlock_event", i), 32'(a_ev), 32'(e.ev));
            check($sformatf("a row%0d axis_snapshot", i), 32'(a_snap), 32'(e.snap));
            check($sformatf("a row%0d first_blocked_idx", i), 32'(a_idx), 32'(e.idx));
            check($sformatf("a row%0d starved_inputs", i), 32'(a_starved), 32'(e.starved));
            check($sformatf("a row%0d unready_outputs", i), 32'(a_unready), 32'(e.unready));
        end

        // ---------------- instance b: single-sample deadlock ----------------
        @(posedge clk);
        #1;
        check("b reset deadlock", 32'(b_dl), 32'd0);
        check("b reset snapshot", 32'(b_snap), 32'd0);
        check("b reset first_blocked_idx", 32'(b_idx), 32'h8);

        b_rst_n = 1'b1;
        b_axis  = 5'b00000;
        @(posedge clk);
        #1;
        check("b idle deadlock", 32'(b_dl), 32'd0);

        b_axis = 5'b10100;
        @(posedge clk);
        #1;
        check("b entry deadlock", 32'(b_dl), 32'd1);
        check("b entry event", 32'(b_ev), 32'd1);
        check("b entry kernel_block", 32'(b_kb), 32'd1);
        check("b entry snapshot", 32'(b_snap), 32'h14);
        check("b first_blocked_idx", 32'(b_idx), 32'd2);
        check("b starved_inputs", 32'(b_starved), 32'h10);
        check("b unready_outputs", 32'(b_unready), 32'h04);

        b_axis = 5'b00011;
        @(posedge clk);
        #1;
        check("b sticky deadlock", 32'(b_dl), 32'd1);
        check("b event one-shot", 32'(b_ev), 32'd0);
        check("b snapshot frozen", 32'(b_snap), 32'h14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
